// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the 4-bit opcode map.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9,
        OP_ROL = 4'd10,
        OP_ROR = 4'd11
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: computes the next result and carry/borrow from A, B and sel.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result_d,
    output logic             carry_d
);

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    // Widened by one bit so the top bit holds carry (add) or borrow (subtract).
    logic [WIDTH:0] add_s;
    logic [WIDTH:0] sub_s;
    logic [WIDTH:0] inc_s;
    logic [WIDTH:0] dec_s;

    assign add_s = {1'b0, A} + {1'b0, B};
    assign sub_s = {1'b0, A} - {1'b0, B};
    assign inc_s = {1'b0, A} + ONE_EXT;
    assign dec_s = {1'b0, A} - ONE_EXT;

    // Opcode decode; reserved codes yield zero result and no carry.
    always_comb begin
        result_d = {WIDTH{1'b0}};
        carry_d  = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD: begin result_d = add_s[WIDTH-1:0]; carry_d = add_s[WIDTH]; end
            OP_SUB: begin result_d = sub_s[WIDTH-1:0]; carry_d = sub_s[WIDTH]; end
            OP_AND: begin result_d = A & B;            carry_d = 1'b0;         end
            OP_OR:  begin result_d = A | B;            carry_d = 1'b0;         end
            OP_XOR: begin result_d = A ^ B;            carry_d = 1'b0;         end
            OP_NOT: begin result_d = ~A;               carry_d = 1'b0;         end
            OP_SHL: begin result_d = {A[WIDTH-2:0], 1'b0}; carry_d = A[WIDTH-1]; end
            OP_SHR: begin result_d = {1'b0, A[WIDTH-1:1]}; carry_d = A[0];       end
            OP_INC: begin result_d = inc_s[WIDTH-1:0]; carry_d = inc_s[WIDTH]; end
            OP_DEC: begin result_d = dec_s[WIDTH-1:0]; carry_d = dec_s[WIDTH]; end
            OP_ROL: begin result_d = {A[WIDTH-2:0], A[WIDTH-1]}; carry_d = A[WIDTH-1]; end
            OP_ROR: begin result_d = {A[0], A[WIDTH-1:1]};       carry_d = A[0];       end
            default: begin result_d = {WIDTH{1'b0}}; carry_d = 1'b0; end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency result, carry and zero flag with async active-high reset.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             zero_d;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .A        (A),
        .B        (B),
        .sel      (sel),
        .result_d (result_d),
        .carry_d  (carry_d)
    );

    // Zero flag is derived from the next result so it lands in the same cycle as result.
    always_comb begin
        zero_d = 1'b0;
        if (result_d == {WIDTH{1'b0}}) begin
            zero_d = 1'b1;
        end else begin
            zero_d = 1'b0;
        end
    end

    // Output registers; reset forces the all-zero result state without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, compared one edge later.
module tb_alu;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] A   = 8'd0;
    logic [7:0] B   = 8'd0;
    logic [3:0] sel = 4'd0;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    alu #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int s, input string nm);
        exp_t e;
        int   r;
        int   c;
        r = 0;
        c = 0;
        case (s)
            0:  begin r = a + b; c = (r > 255) ? 1 : 0; end
            1:  begin r = a - b; c = (a < b) ? 1 : 0; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  begin r = a * 2; c = a / 128; end
            7:  begin r = a / 2; c = a % 2; end
            8:  begin r = a + 1; c = (a == 255) ? 1 : 0; end
            9:  begin r = a - 1; c = (a == 0) ? 1 : 0; end
            10: begin r = a * 2 + a / 128; c = a / 128; end
            11: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
            default: begin r = 0; c = 0; end
        endcase
        r = r & 255;
        e.r = 8'(r);
        e.c = (c != 0);
        e.z = (r == 0);
        e.name = nm;
        return e;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input exp_t e);
        A   = a;
        B   = b;
        sel = s;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_async: got r=%0d c=%0b z=%0b, want r=0 c=0 z=1", result, carry, zero);
        end
        drive(8'd200, 8'd100, 4'd0, model(200, 100, 0, "unused"));
        void'(sb.pop_back());
        @(posedge clk); #1;
        vectors++;
        if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold: got r=%0d c=%0b z=%0b, want r=0 c=0 z=1", result, carry, zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_r [12] = '{8'd13, 8'd7, 8'd2, 8'd11, 8'd9, 8'd245,
                                   8'd20, 8'd5, 8'd11, 8'd9, 8'd20, 8'd5};
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.r = exp_r[i]; e.c = 1'b0; e.z = 1'b0; e.name = "sweep";
            drive(8'd10, 8'd3, 4'(i), e);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (result !== e.r || carry !== e.c || zero !== e.z) begin
                miscompares++;
                $display("FAIL %s sel=%0d: got r=%0d c=%0b z=%0b, want r=%0d c=%0b z=%0b",
                         e.name, i, result, carry, zero, e.r, e.c, e.z);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta [7] = '{8'd255, 8'd3, 8'h81, 8'h01, 8'd0, 8'h5A, 8'h80};
        logic [7:0] tb [7] = '{8'd1, 8'd10, 8'd77, 8'd99, 8'd5, 8'h5A, 8'd0};
        logic [3:0] ts [7] = '{4'd0, 4'd1, 4'd6, 4'd11, 4'd9, 4'd4, 4'd10};
        logic [7:0] tr [7] = '{8'd0, 8'd249, 8'h02, 8'h80, 8'd255, 8'd0, 8'h01};
        logic       tc [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       tz [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            e.r = tr[i]; e.c = tc[i]; e.z = tz[i]; e.name = "corner";
            drive(ta[i], tb[i], ts[i], e);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (result !== e.r || carry !== e.c || zero !== e.z) begin
                miscompares++;
                $display("FAIL %s %0d: got r=%0d c=%0b z=%0b, want r=%0d c=%0b z=%0b",
                         e.name, i, result, carry, zero, e.r, e.c, e.z);
            end
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        for (int s = 12; s < 16; s++) begin
            e.r = 8'd0; e.c = 1'b0; e.z = 1'b1; e.name = "reserved";
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(s), e);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (result !== e.r || carry !== e.c || zero !== e.z) begin
                miscompares++;
                $display("FAIL %s sel=%0d: got r=%0d c=%0b z=%0b, want r=0 c=0 z=1",
                         e.name, s, result, carry, zero);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   a, b, s;
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            s = $urandom_range(0, 15);
            drive(8'(a), 8'(b), 4'(s), model(a, b, s, "random"));
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if (result !== e.r || carry !== e.c || zero !== e.z) begin
                miscompares++;
                $display("FAIL %s a=%0d b=%0d sel=%0d: got r=%0d c=%0b z=%0b, want r=%0d c=%0b z=%0b",
                         e.name, a, b, s, result, carry, zero, e.r, e.c, e.z);
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        drive(8'd20, 8'd30, 4'd0, model(20, 30, 0, "pre_reset"));
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (result !== e.r || carry !== e.c || zero !== e.z) begin
            miscompares++;
            $display("FAIL %s: got r=%0d c=%0b z=%0b, want r=%0d c=%0b z=%0b",
                     e.name, result, carry, zero, e.r, e.c, e.z);
        end
        A = 8'd100; B = 8'd100; sel = 4'd0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_async: got r=%0d c=%0b z=%0b, want r=0 c=0 z=1", result, carry, zero);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_reset_hold %0d: got r=%0d c=%0b z=%0b, want r=0 c=0 z=1",
                         i, result, carry, zero);
            end
        end
        #3 rst = 1'b0;
        drive(8'd7, 8'd8, 4'd0, model(7, 8, 0, "post_reset"));
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if (result !== e.r || carry !== e.c || zero !== e.z) begin
            miscompares++;
            $display("FAIL %s: got r=%0d c=%0b z=%0b, want r=%0d c=%0b z=%0b",
                     e.name, result, carry, zero, e.r, e.c, e.z);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_corners();
        test_reserved();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
